macc_dot: RTL and testbench
===========================

# macc_dot

Streaming dot-product engine: the compute stage directly downstream of the matrix A/B datapaths in the MACC accelerator. It consumes paired A-row/B-column elements from those datapaths' read outputs and accumulates their signed products. It then emits one 32-bit result element toward matrix C's write port. Each `start` produces exactly one C element.

## Interface
Parameters:
- `DATA_W`, default 32: operand and result width, two's complement.
- `LEN_W`, default 10: width of the `len` count, matching the 10-bit row/column counters in the matrix control blocks.
- `ACC_W`, default 2*DATA_W+LEN_W (74): accumulator width. No internal overflow is possible at this width.

Ports:
- `CLK` in 1: the single clock. All state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `VDD`, `GND` in 1: power pins, present for consistency with the accelerator's other blocks; functionally unused.
- `start` in 1: begin a new dot product. Honoured only in IDLE.
- `len` in LEN_W: number of element pairs minus 1 (0 → 1 pair, 1023 → 1024 pairs). Sampled when `start` is accepted.
- `in_valid` in 1: the `a_in`/`b_in` pair is valid.
- `in_ready` out 1: the engine accepts a pair this cycle.
- `a_in` in DATA_W: element from matrix A.
- `b_in` in DATA_W: element from matrix B.
- `c_out` out DATA_W: result element.
- `c_valid` out 1: `c_out` is valid.
- `c_ready` in 1: the C-side consumer accepts the result.
- `busy` out 1: high in every state except IDLE.
- `sat` out 1: sticky flag. Set when the result was clamped; cleared on an accepted `start`.

## Operation
- States: IDLE, ACCUM, DRAIN, OUTPUT.
- IDLE → ACCUM on `start`. On that edge:
  - latch `len` into `len_q`;
  - clear `cnt`, `acc`, `prod_v` and `sat`.
- ACCUM:
  - `in_ready` is 1.
  - A pair is accepted when `in_valid && in_ready`. On that edge, `prod_q` ← signed(`a_in`) × signed(`b_in`) (2*DATA_W bits), `prod_v` ← 1 and `cnt` increments.
  - On a cycle with no handshake, `prod_v` ← 0.
  - Whenever `prod_v` is 1, `acc` ← `acc` + sign-extended `prod_q`.
  - When the accepted pair has `cnt == len_q`, go to DRAIN.
- DRAIN (exactly 1 cycle):
  - `in_ready` is 0.
  - The final product is added to `acc`.
  - Go to OUTPUT.
- OUTPUT:
  - `c_valid` is 1 and `c_out` = result(`acc`).
  - `c_out` stays stable while `c_ready` is 0.
  - On `c_valid && c_ready`, go to IDLE.
  - `sat` is updated on entry to OUTPUT.
- `start` outside IDLE is ignored; `len` is not resampled.
- Input stalls (`in_valid` low) are allowed at any point in ACCUM. They insert bubbles and do not affect the result.
- `in_valid` in IDLE, DRAIN or OUTPUT is not accepted and has no effect.

## Timing
- Reset values (asynchronous, immediate) — all outputs 0:
  - state = IDLE;
  - `in_ready`, `c_valid`, `busy`, `sat` = 0;
  - `c_out` = 0;
  - `cnt`, `len_q`, `acc`, `prod_q`, `prod_v` = 0.
- Reset asserted mid-operation aborts the operation. No output is produced, and the next `start` after reset release behaves normally.
- `in_ready` rises on the cycle after `start` is sampled. A pair presented in the same cycle as `start` is not accepted.
- Latency: `c_valid` rises 2 cycles after the edge on which the last pair was accepted (one cycle in DRAIN).
- Throughput: one pair per cycle. Minimum period of a full operation is (len+1) + 3 cycles when `c_ready` is held high.
- `busy` = 1 from the edge after `start` up to and including the `c_ready` handshake cycle.

## Configuration
- `MACC_DOT_SAT_EN` defined:
  - result(`acc`) clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
  - `sat` is set if clamping occurred.
- `MACC_DOT_SAT_EN` undefined:
  - result = `acc`[DATA_W-1:0] (wrap);
  - `sat` is tied to 0.

## Structure
- Package `macc_pkg`:
  - state enum (IDLE, ACCUM, DRAIN, OUTPUT);
  - default `DATA_W`/`LEN_W`/`ACC_W` constants, shared with the other matrix control blocks.
- One sub-module, `macc_sat`: a combinational ACC_W→DATA_W saturator with an overflow flag output. It is instantiated only under `MACC_DOT_SAT_EN`.

## Test plan
- **Basic dot product:** `len`=3, A={1,2,3,4}, B={5,6,7,8} streamed back-to-back, `c_ready`=1 → `c_out`=70 (0x46). `c_valid` rises 2 cycles after the 4th accept; `sat`=0.
- **Signed, single pair:** `len`=0, A={-3}, B={4} → `c_out`=0xFFFFFFF4. The full operation takes 4 cycles from `start`.
- **Overflow:** `len`=1, A={0x7FFFFFFF,0x7FFFFFFF}, B={2,2}:
  - with `MACC_DOT_SAT_EN` → `c_out`=0x7FFFFFFF, `sat`=1;
  - without it → `c_out`=0xFFFFFFFC, `sat`=0.
- **Stalls and backpressure:**
  - `in_valid` toggled 1/0 each cycle during the basic case → result is still 70;
  - `c_ready` held 0 for 5 cycles in OUTPUT → `c_out` and `c_valid` stay stable;
  - `start` pulsed during OUTPUT → ignored.
- **Reset mid-operation:** `RST` pulsed after 2 of 4 pairs → all outputs are 0 immediately. A new `start` with `len`=0, A={7}, B={6} then yields `c_out`=42.
- **Maximum length:** `len`=1023 with all pairs A=1, B=1 → `c_out`=1024, and `cnt` wrap does not cause an early exit.

Source files
------------

// File: rtl/macc_pkg.sv
// macc_pkg: shared types and default widths for the MACC accelerator blocks.
//   state_e          : dot-product engine states (IDLE, ACCUM, DRAIN, OUTPUT)
//   MACC_DATA_W      : default operand/result width
//   MACC_LEN_W       : default row/column count width (matches 10-bit counters)
//   MACC_ACC_W       : default accumulator width, wide enough to never overflow
package macc_pkg;
  localparam int MACC_DATA_W = 32;
  localparam int MACC_LEN_W  = 10;
  localparam int MACC_ACC_W  = 2*MACC_DATA_W + MACC_LEN_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;
endpackage

// File: rtl/macc_dot_if.sv
// macc_dot_if: operand stream in, result stream out, plus status.
//   master : the side driving start/len, the A/B pair stream and c_ready
//   slave  : the dot-product engine
//   start, len         : kick off one dot product of len+1 pairs
//   in_valid/in_ready  : A/B pair handshake (a_in, b_in)
//   c_valid/c_ready    : result handshake (c_out)
//   busy, sat          : engine active, result clamped (sticky)
interface macc_dot_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 10
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] c_out;
  logic              c_valid;
  logic              c_ready;
  logic              busy;
  logic              sat;

  modport master (
    output start, len, in_valid, a_in, b_in, c_ready,
    input  in_ready, c_out, c_valid, busy, sat
  );

  modport slave (
    input  start, len, in_valid, a_in, b_in, c_ready,
    output in_ready, c_out, c_valid, busy, sat
  );
endinterface

// File: rtl/macc_sat.sv
// macc_sat: combinational signed saturator, ACC_W -> DATA_W.
//   acc_i : two's complement accumulator value
//   res_o : acc_i clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]
//   ovf_o : 1 when clamping occurred
module macc_sat #(
  parameter int ACC_W  = 74,
  parameter int DATA_W = 32
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [DATA_W-1:0] res_o,
  output logic              ovf_o
);
  // Value fits iff every bit from the result's sign bit upward is identical.
  logic [ACC_W-DATA_W:0] upper;
  assign upper = acc_i[ACC_W-1:DATA_W-1];
  assign ovf_o = !((&upper) || !(|upper));

  always_comb begin
    res_o = acc_i[DATA_W-1:0];
    if (ovf_o)
      res_o = acc_i[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
  end
endmodule

// File: rtl/macc_dot.sv
// macc_dot: streaming signed dot-product engine. One start -> one C element.
//   CLK, RST   : clock, asynchronous active-high reset
//   VDD, GND   : power pins, functionally unused
//   bus        : macc_dot_if.slave (start/len, A/B pair stream, C result, busy/sat)
// Build option: define MACC_DOT_SAT_EN to clamp the result to DATA_W and
// report clamping on sat; otherwise the result wraps and sat stays 0.
module macc_dot
  import macc_pkg::*;
#(
  parameter int DATA_W = MACC_DATA_W,
  parameter int LEN_W  = MACC_LEN_W,
  parameter int ACC_W  = 2*DATA_W + LEN_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic VDD,
  input  logic GND,
  macc_dot_if.slave bus
);
  localparam int PROD_W = 2*DATA_W;

  state_e              state_q;
  logic [LEN_W-1:0]    len_q, cnt_q;
  logic [ACC_W-1:0]    acc_q;
  logic [PROD_W-1:0]   prod_q;
  logic                prod_v_q;
  logic                in_ready_q, c_valid_q, busy_q, sat_q;
  logic [DATA_W-1:0]   c_out_q;

  logic                unused_pwr;
  assign unused_pwr = VDD ^ GND;

  // Full-width product of sign-extended operands; the low PROD_W bits are exact.
  logic [PROD_W-1:0] a_ext, b_ext, prod_w;
  assign a_ext  = {{DATA_W{bus.a_in[DATA_W-1]}}, bus.a_in};
  assign b_ext  = {{DATA_W{bus.b_in[DATA_W-1]}}, bus.b_in};
  assign prod_w = a_ext * b_ext;

  // Accumulator value after folding in the pending product; in DRAIN this is
  // the final sum, so the result register is loaded from it directly.
  logic [ACC_W-1:0] acc_nxt;
  assign acc_nxt = prod_v_q ? acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q}
                            : acc_q;

  logic [DATA_W-1:0] res;
  logic              ovf;
`ifdef MACC_DOT_SAT_EN
  macc_sat #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_sat (
    .acc_i (acc_nxt),
    .res_o (res),
    .ovf_o (ovf)
  );
`else
  assign res = acc_nxt[DATA_W-1:0];
  assign ovf = 1'b0;
`endif

  logic accept;
  assign accept = bus.in_valid && in_ready_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      prod_v_q   <= 1'b0;
      in_ready_q <= 1'b0;
      c_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      sat_q      <= 1'b0;
      c_out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            len_q      <= bus.len;
            cnt_q      <= '0;
            acc_q      <= '0;
            prod_v_q   <= 1'b0;
            sat_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_nxt;
          if (accept) begin
            prod_q   <= prod_w;
            prod_v_q <= 1'b1;
            cnt_q    <= cnt_q + LEN_W'(1);
            // Exit is decided on the compare, so cnt wrapping at max len is harmless.
            if (cnt_q == len_q) begin
              in_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end
          end else begin
            prod_v_q <= 1'b0;
          end
        end
        DRAIN: begin
          acc_q     <= acc_nxt;
          prod_v_q  <= 1'b0;
          c_out_q   <= res;
          sat_q     <= ovf;
          c_valid_q <= 1'b1;
          state_q   <= OUTPUT;
        end
        OUTPUT: begin
          if (bus.c_ready) begin
            c_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.c_valid  = c_valid_q;
  assign bus.c_out    = c_out_q;
  assign bus.busy     = busy_q;
  assign bus.sat      = sat_q;
endmodule

// File: tb/tb_macc_dot.sv
module tb_macc_dot;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  macc_dot_if #(.DATA_W(32), .LEN_W(10)) bus ();

  macc_dot dut (
    .CLK (CLK),
    .RST (RST),
    .VDD (1'b1),
    .GND (1'b0),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;
  logic [31:0] av [0:1023];
  logic [31:0] bv [0:1023];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [9:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
    bus.len   = 10'h3FF;  // must not be resampled
  endtask

  // Present n pairs; with stall set, a bubble follows every pair but the last.
  task automatic feed(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.a_in     = av[i];
      bus.b_in     = bv[i];
      tick();
      if (stall && i < n-1) begin
        bus.in_valid = 1'b0;
        bus.a_in     = 32'hDEAD_BEEF;
        bus.b_in     = 32'h1234_5678;
        tick();
      end
    end
    bus.in_valid = 1'b1;  // held high: must be ignored in DRAIN/OUTPUT
    bus.a_in     = 32'h0BAD_0BAD;
    bus.b_in     = 32'h0BAD_0BAD;
  endtask

  // Called right after the last accept edge, c_ready high.
  task automatic finish_op(input string tag, input logic [31:0] exp_c, input logic exp_sat);
    chk({tag, ".drain_cvalid"}, bus.c_valid, 1'b0);
    chk({tag, ".drain_inready"}, bus.in_ready, 1'b0);
    tick();
    chk({tag, ".cvalid"}, bus.c_valid, 1'b1);
    chk({tag, ".cout"}, bus.c_out, exp_c);
    chk({tag, ".sat"}, bus.sat, exp_sat);
    chk({tag, ".busy_out"}, bus.busy, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, ".idle_busy"}, bus.busy, 1'b0);
    chk({tag, ".idle_cvalid"}, bus.c_valid, 1'b0);
  endtask

  initial begin
    RST = 1'b1;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.a_in = '0; bus.b_in = '0; bus.c_ready = 1'b1;
    #12;
    chk("rst.inready", bus.in_ready, 1'b0);
    chk("rst.cvalid", bus.c_valid, 1'b0);
    chk("rst.cout", bus.c_out, 32'h0);
    chk("rst.busy", bus.busy, 1'b0);
    chk("rst.sat", bus.sat, 1'b0);
    @(negedge CLK); RST = 1'b0;
    tick();

    // Basic: 1*5+2*6+3*7+4*8 = 70; pair shown with start must not count.
    av[0]=1; av[1]=2; av[2]=3; av[3]=4;
    bv[0]=5; bv[1]=6; bv[2]=7; bv[3]=8;
    bus.in_valid = 1'b1; bus.a_in = 32'd100; bus.b_in = 32'd100;
    chk("basic.idle_inready", bus.in_ready, 1'b0);
    do_start(10'd3);
    chk("basic.inready", bus.in_ready, 1'b1);
    chk("basic.busy", bus.busy, 1'b1);
    chk("basic.sat_clr", bus.sat, 1'b0);
    feed(4, 1'b0);
    finish_op("basic", 32'd70, 1'b0);

    // Single signed pair, 4 cycles from start to idle.
    av[0] = -32'sd3; bv[0] = 32'd4;
    do_start(10'd0);                                   // cycle 1
    feed(1, 1'b0);                                     // cycle 2
    finish_op("single", 32'hFFFF_FFF4, 1'b0);          // cycles 3,4

    // Overflow: 0x7FFFFFFF*2 twice = 0x1_FFFF_FFFC.
    av[0] = 32'h7FFF_FFFF; av[1] = 32'h7FFF_FFFF;
    bv[0] = 32'd2; bv[1] = 32'd2;
    do_start(10'd1);
    feed(2, 1'b0);
`ifdef MACC_DOT_SAT_EN
    finish_op("ovf", 32'h7FFF_FFFF, 1'b1);
    bus.len = 10'd0; bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("ovf.sat_clr_on_start", bus.sat, 1'b0);
    av[0] = 32'd0; bv[0] = 32'd0;
    feed(1, 1'b0);
    finish_op("zero", 32'd0, 1'b0);
`else
    finish_op("ovf", 32'hFFFF_FFFC, 1'b0);
`endif

    // Stalls + backpressure + start during OUTPUT.
    av[0]=1; av[1]=2; av[2]=3; av[3]=4;
    bv[0]=5; bv[1]=6; bv[2]=7; bv[3]=8;
    bus.c_ready = 1'b0;
    do_start(10'd3);
    feed(4, 1'b1);
    chk("bp.drain_cvalid", bus.c_valid, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp.hold_cvalid", bus.c_valid, 1'b1);
      chk("bp.hold_cout", bus.c_out, 32'd70);
      bus.start = (i == 2);
      bus.len   = 10'd0;
      tick();
    end
    bus.start = 1'b0;
    chk("bp.still_cvalid", bus.c_valid, 1'b1);
    bus.c_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("bp.idle_busy", bus.busy, 1'b0);
    tick();
    chk("bp.start_ignored_busy", bus.busy, 1'b0);
    chk("bp.start_ignored_inready", bus.in_ready, 1'b0);

    // Reset mid-operation.
    do_start(10'd3);
    bus.in_valid = 1'b1;
    bus.a_in = 32'd1; bus.b_in = 32'd5; tick();
    bus.a_in = 32'd2; bus.b_in = 32'd6; tick();
    bus.in_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("midrst.inready", bus.in_ready, 1'b0);
    chk("midrst.busy", bus.busy, 1'b0);
    chk("midrst.cvalid", bus.c_valid, 1'b0);
    chk("midrst.cout", bus.c_out, 32'h0);
    chk("midrst.sat", bus.sat, 1'b0);
    @(negedge CLK); RST = 1'b0;
    tick();
    av[0] = 32'd7; bv[0] = 32'd6;
    do_start(10'd0);
    feed(1, 1'b0);
    finish_op("postrst", 32'd42, 1'b0);

    // Maximum length: 1024 pairs of 1*1.
    for (int i = 0; i < 1024; i++) begin av[i] = 32'd1; bv[i] = 32'd1; end
    do_start(10'd1023);
    feed(1023, 1'b0);
    chk("maxlen.no_early_exit", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.a_in = 32'd1; bus.b_in = 32'd1;
    tick();
    bus.in_valid = 1'b0;
    finish_op("maxlen", 32'd1024, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
